// File: rtl/ram_behavior.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_behavior                                                  |
// | Summary  : Simple dual-port RAM, 2^AW x DW, one write and one registered |
// |            read port on a single clock. RAM_WRITE_BYPASS_EN selects      |
// |            write-first on same-address collisions (default read-first).  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram_behavior #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_en,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic          r_en,
  input  logic [AW-1:0] r_addr,
  output logic [DW-1:0] r_data
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word;

`ifdef RAM_WRITE_BYPASS_EN
  // Write-first: a same-edge write to the read address forwards its data.
  assign rd_word = (w_en && (w_addr == r_addr)) ? w_data : mem[r_addr];
`else
  assign rd_word = mem[r_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[AW-1:0]] <= '0;
      end
      r_data <= '0;
    end else begin
      if (w_en) begin
        mem[w_addr] <= w_data;
      end
      if (r_en) begin
        r_data <= rd_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_behavior.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_behavior                                               |
// | Summary  : Directed self-checking bench for ram_behavior (AW=5, DW=8).   |
// |            Collision expectation follows RAM_WRITE_BYPASS_EN.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ram_behavior;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  int n_cmp;
  int n_err;

  ram_behavior #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (w_en),
    .w_addr (w_addr),
    .w_data (w_data),
    .r_en   (r_en),
    .r_addr (r_addr),
    .r_data (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] fill_exp [9];
  logic [DW-1:0] coll_exp;

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 7; i++) fill_exp[i] = DW'(i);
    fill_exp[7] = 8'hFD;
    fill_exp[8] = 8'hFE;
`ifdef RAM_WRITE_BYPASS_EN
    coll_exp = 8'h55;
`else
    coll_exp = 8'h03;
`endif

    rst_n = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; r_en = 1'b0; r_addr = '0;
    tick();
    check("reset_rdata", r_data, 8'h00);
    rst_n = 1'b1;
    r_en = 1'b1; r_addr = 5'd0;
    tick();
    check("idle_read_addr0", r_data, 8'h00);
    r_en = 1'b0;

    // Fill 0..8, then keep addresses/data moving with writes disabled.
    for (int i = 0; i < 9; i++) begin
      w_en = 1'b1; w_addr = AW'(i); w_data = fill_exp[i];
      tick();
    end
    for (int i = 9; i < 11; i++) begin
      w_en = 1'b0; w_addr = AW'(i); w_data = DW'(i);
      tick();
    end

    r_en = 1'b1;
    r_addr = 5'd9;  tick(); check("disabled_write_addr9", r_data, 8'h00);
    r_addr = 5'd10; tick(); check("disabled_write_addr10", r_data, 8'h00);
    r_addr = 5'd8;  tick(); check("read_addr8", r_data, 8'hFE);
    for (int i = 0; i < 8; i++) begin
      r_addr = AW'(i);
      tick();
      check($sformatf("readback_addr%0d", i), r_data, fill_exp[i]);
    end

    r_en = 1'b0;
    r_addr = 5'd10; tick(); check("hold_1", r_data, 8'hFD);
    r_addr = 5'd11; tick(); check("hold_2", r_data, 8'hFD);

    // Same-address collision.
    w_en = 1'b1; w_addr = 5'd3; w_data = 8'h55; r_en = 1'b1; r_addr = 5'd3;
    tick();
    check("collision_same_edge", r_data, coll_exp);
    w_en = 1'b0;
    tick();
    check("collision_next_read", r_data, 8'h55);

    // Independent ports on different addresses, plus the top address.
    w_en = 1'b1; w_addr = 5'd20; w_data = 8'hA5; r_addr = 5'd8;
    tick();
    check("indep_read_addr8", r_data, 8'hFE);
    w_addr = 5'd31; w_data = 8'h80; r_addr = 5'd20;
    tick();
    check("indep_read_addr20", r_data, 8'hA5);
    w_en = 1'b0; r_addr = 5'd31;
    tick();
    check("top_addr31", r_data, 8'h80);

    // Asynchronous reset between edges; a write pending across it is lost.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", r_data, 8'h00);
    w_en = 1'b1; w_addr = 5'd5; w_data = 8'h77; r_en = 1'b1; r_addr = 5'd5;
    tick();
    check("reset_held_rdata", r_data, 8'h00);
    rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0;
    tick();
    check("post_reset_no_read", r_data, 8'h00);
    r_en = 1'b1;
    r_addr = 5'd7;  tick(); check("post_reset_addr7", r_data, 8'h00);
    r_addr = 5'd5;  tick(); check("post_reset_addr5", r_data, 8'h00);
    r_addr = 5'd31; tick(); check("post_reset_addr31", r_data, 8'h00);

    // Memory still works after reset.
    w_en = 1'b1; w_addr = 5'd7; w_data = 8'h3C; r_en = 1'b0;
    tick();
    w_en = 1'b0; r_en = 1'b1; r_addr = 5'd7;
    tick();
    check("post_reset_write", r_data, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
